// File: rtl/jtcop_mcu_bridge.sv
// Main-CPU <-> MCU bridge: edge-triggered MCU interrupts, a main-to-MCU word FIFO
// read byte-wise by the MCU, and a byte-lane assembled word returned to the main CPU.
module jtcop_mcu_bridge #(
    parameter int unsigned      DW      = 16,
    parameter int unsigned      NSEL    = 6,
    parameter logic [NSEL-1:0]  IRQMASK = NSEL'(1),
    parameter int unsigned      DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSEL-1:0] main_sel,
    input  logic            main_wr,
    input  logic [DW-1:0]   main_din,
    output logic [DW-1:0]   main_dout,
    output logic            main_full,
    output logic            main_ovf,
    input  logic [7:0]      mcu_p0o,
    output logic [7:0]      mcu_p0i,
    input  logic [DW/8-1:0] mcu_rd,
    input  logic [DW/8-1:0] mcu_wr,
    input  logic            mcu_pop,
    output logic            mcu_empty,
    output logic            mcu_intn,
    input  logic            mcu_iack,
    output logic [NSEL-1:0] mcu_irqsrc
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [NSEL-1:0] sel_q, pend_q, pend_d, edge_c;
    logic            intn_q;

    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_q, empty_q, ovf_q, ovf_d;
    logic            do_push, do_pop;

    logic [DW-1:0]   head_c;
    logic [7:0]      rd_byte_c;
    logic [7:0]      p0i_q, p0i_d;
    logic [DW-1:0]   dout_q, dout_d;

    // Next-state for interrupts, FIFO bookkeeping and the two byte paths
    always_comb begin
        edge_c    = main_sel & ~sel_q & IRQMASK;
        pend_d    = (mcu_iack ? '0 : pend_q) | edge_c;

        do_pop    = mcu_pop & ~empty_q;
        do_push   = main_wr & (~full_q | do_pop);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q | (main_wr & full_q & ~mcu_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Lowest set read strobe wins, so scan from the top lane down
        head_c    = mem_q[rd_ptr_q];
        rd_byte_c = 8'h00;
        for (int k = int'(NB) - 1; k >= 0; k--) begin
            if (mcu_rd[k]) rd_byte_c = head_c[8*k +: 8];
        end
        p0i_d = p0i_q;
        if (|mcu_rd) p0i_d = empty_q ? 8'h00 : rd_byte_c;

        dout_d = dout_q;
        for (int k = 0; k < int'(NB); k++) begin
            if (mcu_wr[k]) dout_d[8*k +: 8] = mcu_p0o;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= '0;
            pend_q   <= '0;
            intn_q   <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            p0i_q    <= 8'h00;
            dout_q   <= '0;
        end else begin
            sel_q    <= main_sel;
            pend_q   <= pend_d;
            intn_q   <= ~|pend_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CW'(DEPTH));
            empty_q  <= (cnt_d == CW'(0));
            ovf_q    <= ovf_d;
            p0i_q    <= p0i_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= main_din;
    end

    assign main_dout  = dout_q;
    assign main_full  = full_q;
    assign main_ovf   = ovf_q;
    assign mcu_p0i    = p0i_q;
    assign mcu_empty  = empty_q;
    assign mcu_intn   = intn_q;
    assign mcu_irqsrc = pend_q;

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Directed self-checking bench for jtcop_mcu_bridge with default parameters.
module tb_jtcop_mcu_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  main_sel;
    logic        main_wr;
    logic [15:0] main_din;
    logic [15:0] main_dout;
    logic        main_full;
    logic        main_ovf;
    logic [7:0]  mcu_p0o;
    logic [7:0]  mcu_p0i;
    logic [1:0]  mcu_rd;
    logic [1:0]  mcu_wr;
    logic        mcu_pop;
    logic        mcu_empty;
    logic        mcu_intn;
    logic        mcu_iack;
    logic [5:0]  mcu_irqsrc;

    int n_checks = 0;
    int n_fail   = 0;

    jtcop_mcu_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .main_sel   (main_sel),
        .main_wr    (main_wr),
        .main_din   (main_din),
        .main_dout  (main_dout),
        .main_full  (main_full),
        .main_ovf   (main_ovf),
        .mcu_p0o    (mcu_p0o),
        .mcu_p0i    (mcu_p0i),
        .mcu_rd     (mcu_rd),
        .mcu_wr     (mcu_wr),
        .mcu_pop    (mcu_pop),
        .mcu_empty  (mcu_empty),
        .mcu_intn   (mcu_intn),
        .mcu_iack   (mcu_iack),
        .mcu_irqsrc (mcu_irqsrc)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({main_dout, mcu_p0i, mcu_irqsrc, mcu_intn, mcu_empty, main_full, main_ovf}
            !== {16'h0000, 8'h00, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: dout=%h p0i=%h irqsrc=%b intn=%b empty=%b full=%b ovf=%b, required 0000 00 000000 1 1 0 0",
                     tag, main_dout, mcu_p0i, mcu_irqsrc, mcu_intn, mcu_empty, main_full, main_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; main_sel = '0; main_wr = 1'b0; main_din = '0; mcu_p0o = '0;
        mcu_rd = '0; mcu_wr = '0; mcu_pop = 1'b0; mcu_iack = 1'b0;
        tick(); tick();
        check_reset_values("reset_state");
        rst = 1'b0;
        tick();
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_irq();
        main_sel = 6'b000001;
        tick();
        n_checks++;
        if ({mcu_intn, mcu_irqsrc} !== {1'b0, 6'b000001}) begin
            n_fail++;
            $display("FAIL irq_raise: intn=%b irqsrc=%b, required 0 000001", mcu_intn, mcu_irqsrc);
        end
        mcu_iack = 1'b1;
        tick();
        mcu_iack = 1'b0;
        n_checks++;
        if ({mcu_intn, mcu_irqsrc} !== {1'b1, 6'b000000}) begin
            n_fail++;
            $display("FAIL irq_ack: intn=%b irqsrc=%b, required 1 000000", mcu_intn, mcu_irqsrc);
        end
        tick();
        n_checks++;
        if ({mcu_intn, mcu_irqsrc} !== {1'b1, 6'b000000}) begin
            n_fail++;
            $display("FAIL irq_level_no_retrigger: intn=%b irqsrc=%b, required 1 000000", mcu_intn, mcu_irqsrc);
        end
        main_sel = '0;
        tick();
    endtask

    task automatic test_irq_coincide();
        main_sel = 6'b000001; tick();
        main_sel = 6'b000000; tick();
        main_sel = 6'b000001; mcu_iack = 1'b1;
        tick();
        mcu_iack = 1'b0; main_sel = '0;
        n_checks++;
        if ({mcu_intn, mcu_irqsrc} !== {1'b0, 6'b000001}) begin
            n_fail++;
            $display("FAIL irq_edge_with_iack: intn=%b irqsrc=%b, required 0 000001", mcu_intn, mcu_irqsrc);
        end
        mcu_iack = 1'b1; tick(); mcu_iack = 1'b0;
        main_sel = 6'b000010;
        tick();
        n_checks++;
        if ({mcu_intn, mcu_irqsrc} !== {1'b1, 6'b000000}) begin
            n_fail++;
            $display("FAIL irq_masked_sel1: intn=%b irqsrc=%b, required 1 000000", mcu_intn, mcu_irqsrc);
        end
        main_sel = 6'b111110;
        tick();
        n_checks++;
        if ({mcu_intn, mcu_irqsrc} !== {1'b1, 6'b000000}) begin
            n_fail++;
            $display("FAIL irq_masked_upper: intn=%b irqsrc=%b, required 1 000000", mcu_intn, mcu_irqsrc);
        end
        main_sel = '0;
        tick();
    endtask

    task automatic test_fifo_read();
        main_wr = 1'b1; main_din = 16'h1234; tick();
        main_din = 16'hABCD; tick();
        main_wr = 1'b0;
        n_checks++;
        if ({mcu_empty, main_full} !== 2'b00) begin
            n_fail++;
            $display("FAIL fifo_two_pushed: empty=%b full=%b, required 0 0", mcu_empty, main_full);
        end
        mcu_rd = 2'b01; tick();
        n_checks++;
        if (mcu_p0i !== 8'h34) begin
            n_fail++;
            $display("FAIL read_lane0: p0i=%h, required 34", mcu_p0i);
        end
        mcu_rd = 2'b10; tick();
        n_checks++;
        if (mcu_p0i !== 8'h12) begin
            n_fail++;
            $display("FAIL read_lane1: p0i=%h, required 12", mcu_p0i);
        end
        mcu_rd = 2'b00; tick();
        n_checks++;
        if (mcu_p0i !== 8'h12) begin
            n_fail++;
            $display("FAIL read_hold: p0i=%h, required 12", mcu_p0i);
        end
        mcu_pop = 1'b1; tick(); mcu_pop = 1'b0;
        mcu_rd = 2'b11; tick();
        n_checks++;
        if (mcu_p0i !== 8'hCD) begin
            n_fail++;
            $display("FAIL read_both_lanes_low_wins: p0i=%h, required cd", mcu_p0i);
        end
        mcu_rd = 2'b10; mcu_pop = 1'b1; tick();
        mcu_rd = 2'b00; mcu_pop = 1'b0;
        n_checks++;
        if ({mcu_p0i, mcu_empty} !== {8'hAB, 1'b1}) begin
            n_fail++;
            $display("FAIL read_with_pop_prepop: p0i=%h empty=%b, required ab 1", mcu_p0i, mcu_empty);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        main_wr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            main_din = {8'h00, 8'(i * 17)};
            tick();
            if (i == 4) begin
                n_checks++;
                if ({main_full, main_ovf} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL full_after_4: full=%b ovf=%b, required 1 0", main_full, main_ovf);
                end
            end
            if (i == 5) begin
                n_checks++;
                if ({main_full, main_ovf} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL ovf_after_5: full=%b ovf=%b, required 1 1", main_full, main_ovf);
                end
            end
        end
        main_din = 16'h0066; mcu_pop = 1'b1; mcu_rd = 2'b01;
        tick();
        main_wr = 1'b0;
        n_checks++;
        if ({mcu_p0i, main_full} !== {8'h11, 1'b1}) begin
            n_fail++;
            $display("FAIL push_pop_full: p0i=%h full=%b, required 11 1", mcu_p0i, main_full);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (mcu_p0i !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drain_order_%0d: p0i=%h, required %h", i, mcu_p0i, exp_q[i]);
            end
        end
        mcu_pop = 1'b0; mcu_rd = 2'b00;
        n_checks++;
        if ({mcu_empty, main_full, main_ovf} !== 3'b101) begin
            n_fail++;
            $display("FAIL drained_ovf_sticky: empty=%b full=%b ovf=%b, required 1 0 1", mcu_empty, main_full, main_ovf);
        end
    endtask

    task automatic test_mcu_write();
        mcu_p0o = 8'h5A; mcu_wr = 2'b10; tick();
        n_checks++;
        if (main_dout !== 16'h5A00) begin
            n_fail++;
            $display("FAIL write_lane1: dout=%h, required 5a00", main_dout);
        end
        mcu_p0o = 8'hC3; mcu_wr = 2'b01; tick();
        n_checks++;
        if (main_dout !== 16'h5AC3) begin
            n_fail++;
            $display("FAIL write_lane0: dout=%h, required 5ac3", main_dout);
        end
        mcu_p0o = 8'hFF; mcu_wr = 2'b00; tick();
        n_checks++;
        if (main_dout !== 16'h5AC3) begin
            n_fail++;
            $display("FAIL write_hold: dout=%h, required 5ac3", main_dout);
        end
    endtask

    task automatic test_reset_mid();
        main_wr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            main_din = {8'h00, 8'(i)};
            tick();
        end
        main_wr = 1'b0;
        main_sel = 6'b000001; mcu_rd = 2'b01;
        tick();
        mcu_rd = 2'b00;
        n_checks++;
        if ({mcu_intn, mcu_empty, mcu_p0i} !== {1'b0, 1'b0, 8'h01}) begin
            n_fail++;
            $display("FAIL pre_reset_state: intn=%b empty=%b p0i=%h, required 0 0 01", mcu_intn, mcu_empty, mcu_p0i);
        end
        rst = 1'b1;
        #2;
        check_reset_values("async_reset_mid");
        tick();
        check_reset_values("reset_held_mid");
        rst = 1'b0;
        tick();
        n_checks++;
        if ({mcu_intn, mcu_irqsrc, mcu_empty} !== {1'b0, 6'b000001, 1'b1}) begin
            n_fail++;
            $display("FAIL sel_held_through_reset: intn=%b irqsrc=%b empty=%b, required 0 000001 1",
                     mcu_intn, mcu_irqsrc, mcu_empty);
        end
        mcu_iack = 1'b1; tick(); mcu_iack = 1'b0; main_sel = '0;
        mcu_pop = 1'b1; mcu_rd = 2'b01;
        tick();
        mcu_rd = 2'b00;
        n_checks++;
        if ({mcu_p0i, mcu_empty, main_full} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pop_read_empty: p0i=%h empty=%b full=%b, required 00 1 0", mcu_p0i, mcu_empty, main_full);
        end
        main_wr = 1'b1; main_din = 16'h00EE;
        tick();
        main_wr = 1'b0; mcu_pop = 1'b0;
        n_checks++;
        if (mcu_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_empty: empty=%b, required 0", mcu_empty);
        end
        mcu_rd = 2'b01; mcu_pop = 1'b1;
        tick();
        mcu_rd = 2'b00; mcu_pop = 1'b0;
        n_checks++;
        if ({mcu_p0i, mcu_empty} !== {8'hEE, 1'b1}) begin
            n_fail++;
            $display("FAIL single_entry_after_empty: p0i=%h empty=%b, required ee 1", mcu_p0i, mcu_empty);
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_irq_coincide();
        test_fifo_read();
        test_overflow();
        test_mcu_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
